reg_to_axi: RTL and testbench

//  Protocol converter from the register interface to AXI4: a regbus device port drives an AXI4 manager port.

---
 rtl/reg_to_axi.sv | 254 +++++++++++++++++++++++++
 tb/tb_reg_to_axi.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_axi.sv
// Regbus-to-AXI4 manager bridge: every register access is turned into one
// single-beat AXI transaction, and only one transaction is ever in flight.
package reg_to_axi_pkg;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 1;

    typedef struct packed {
        logic [IW-1:0] id;     logic [AW-1:0] addr;   logic [7:0] len;
        logic [2:0]    size;   logic [1:0]    burst;  logic       lock;
        logic [3:0]    cache;  logic [2:0]    prot;   logic [3:0] qos;
        logic [3:0]    region; logic [5:0]    atop;   logic [UW-1:0] user;
    } aw_chan_t;
    typedef struct packed {
        logic [IW-1:0] id;     logic [AW-1:0] addr;   logic [7:0] len;
        logic [2:0]    size;   logic [1:0]    burst;  logic       lock;
        logic [3:0]    cache;  logic [2:0]    prot;   logic [3:0] qos;
        logic [3:0]    region; logic [UW-1:0] user;
    } ar_chan_t;
    typedef struct packed {
        logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; logic [UW-1:0] user;
    } w_chan_t;
    typedef struct packed {
        logic [IW-1:0] id; logic [1:0] resp; logic [UW-1:0] user;
    } b_chan_t;
    typedef struct packed {
        logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic [UW-1:0] user;
    } r_chan_t;
    typedef struct packed {
        aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        ar_chan_t ar; logic ar_valid; logic r_ready;
    } axi_req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        logic b_valid; b_chan_t b; logic r_valid; r_chan_t r;
    } axi_rsp_t;
    typedef struct packed {
        logic [AW-1:0] addr; logic write; logic [DW-1:0] wdata; logic [DW/8-1:0] wstrb; logic valid;
    } reg_req_t;
    typedef struct packed {
        logic [DW-1:0] rdata; logic error; logic ready;
    } reg_rsp_t;
endpackage

module reg_to_axi #(
    parameter int unsigned         ADDR_WIDTH = 32,
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         ID_WIDTH   = 4,
    parameter int unsigned         USER_WIDTH = 1,
    parameter logic [ID_WIDTH-1:0] AXI_ID     = '0,
    parameter type axi_req_t = reg_to_axi_pkg::axi_req_t,
    parameter type axi_rsp_t = reg_to_axi_pkg::axi_rsp_t,
    parameter type reg_req_t = reg_to_axi_pkg::reg_req_t,
    parameter type reg_rsp_t = reg_to_axi_pkg::reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output axi_req_t axi_req_o,
    input  axi_rsp_t axi_rsp_i
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  AXI_SIZE   = 3'($clog2(STRB_WIDTH));

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WAIT_B = 3'd2,
        RD     = 3'd3,
        WAIT_R = 3'd4,
        REPLY  = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    ready_q, ready_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    b_ready_q, b_ready_d;
    logic                    r_ready_q, r_ready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    aw_hs_s, w_hs_s, aw_done_s, w_done_s;

    // Next state, captured request and handshake bookkeeping
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        ready_d    = 1'b0;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        b_ready_d  = b_ready_q;
        r_ready_d  = r_ready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_hs_s    = aw_valid_q & axi_rsp_i.aw_ready;
        w_hs_s     = w_valid_q & axi_rsp_i.w_ready;
        aw_done_s  = aw_done_q | aw_hs_s;
        w_done_s   = w_done_q | w_hs_s;
        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    addr_d  = reg_req_i.addr;
                    wdata_d = reg_req_i.wdata;
                    wstrb_d = reg_req_i.wstrb;
                    if (reg_req_i.write) begin
                        state_d    = WR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD;
                        ar_valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                // Each valid retires on its own handshake; leave once both are done
                aw_valid_d = aw_valid_q & ~aw_hs_s;
                w_valid_d  = w_valid_q & ~w_hs_s;
                aw_done_d  = aw_done_s;
                w_done_d   = w_done_s;
                if (aw_done_s && w_done_s) begin
                    state_d   = WAIT_B;
                    b_ready_d = 1'b1;
                end else begin
                    state_d = WR;
                end
            end
            WAIT_B: begin
                if (axi_rsp_i.b_valid) begin
                    b_ready_d = 1'b0;
                    error_d   = axi_rsp_i.b.resp[1];
                    rdata_d   = '0;
                    ready_d   = 1'b1;
                    state_d   = REPLY;
                end else begin
                    state_d = WAIT_B;
                end
            end
            RD: begin
                if (axi_rsp_i.ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = WAIT_R;
                end else begin
                    state_d = RD;
                end
            end
            WAIT_R: begin
                if (axi_rsp_i.r_valid) begin
                    r_ready_d = 1'b0;
                    rdata_d   = axi_rsp_i.r.data;
                    error_d   = axi_rsp_i.r.resp[1];
                    ready_d   = 1'b1;
                    state_d   = REPLY;
                end else begin
                    state_d = WAIT_R;
                end
            end
            REPLY: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d    = IDLE;
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                ar_valid_d = 1'b0;
                b_ready_d  = 1'b0;
                r_ready_d  = 1'b0;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Drive the port structs straight from registers; unused AXI fields stay zero
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = AXI_SIZE;
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data   = wdata_q;
        axi_req_o.w.strb   = wstrb_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready_q;
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = AXI_SIZE;
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar_valid = ar_valid_q;
        axi_req_o.r_ready  = r_ready_q;
        reg_rsp_o          = '0;
        reg_rsp_o.rdata    = rdata_q;
        reg_rsp_o.error    = error_q;
        reg_rsp_o.ready    = ready_q;
    end

endmodule

// File: tb/tb_reg_to_axi.sv
// Randomized bench for reg_to_axi: a regbus master, an AXI subordinate with
// programmable latencies/responses, and a memory model of expected contents.
module tb_reg_to_axi;
    import reg_to_axi_pkg::*;

    localparam logic [3:0] TB_ID = 4'h5;

    logic     clk = 1'b0;
    logic     rst_n;
    reg_req_t req;
    reg_rsp_t rsp;
    axi_req_t areq;
    axi_rsp_t arsp;

    always #5 clk = ~clk;

    reg_to_axi #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .AXI_ID(TB_ID),
        .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t), .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp),
        .axi_req_o(areq), .axi_rsp_i(arsp)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // subordinate configuration and bookkeeping
    int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    int aw_wait, w_wait, ar_wait, r_wait;
    bit aw_got, w_got, b_pend, r_pend, aw_fp, w_fp, ar_fp, b_fp, r_fp;
    logic [31:0] aw_addr_s, ar_addr_s, w_data_s;
    logic [3:0]  w_strb_s;
    int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_rdy = 0, n_consec = 0;
    int exp_aw = 0, exp_w = 0, exp_ar = 0, exp_b = 0, exp_r = 0, exp_rdy = 0;
    bit rdy_prev = 1'b0;
    logic [31:0] sub_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    // len, size, burst, id, lock/cache/prot/qos/region, user for a 32-bit single beat
    logic [35:0] exp_ar_fix;
    logic [41:0] exp_aw_fix;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // AXI subordinate: drives readies/responses at the falling edge, checks beats
    initial begin
        arsp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arsp = '0; aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_fp = 0; w_fp = 0; ar_fp = 0; b_fp = 0; r_fp = 0;
            end else begin
                if (aw_fp || aw_got) check_val("aw_valid_drop", 64'(areq.aw_valid), 64'd0);
                if (w_fp || w_got)   check_val("w_valid_drop", 64'(areq.w_valid), 64'd0);
                if (ar_fp)           check_val("ar_valid_drop", 64'(areq.ar_valid), 64'd0);
                aw_fp = 0; w_fp = 0; ar_fp = 0;
                if (b_fp) arsp.b_valid = 1'b0;
                if (r_fp) arsp.r_valid = 1'b0;
                b_fp = 0; r_fp = 0;
                if (b_pend) begin
                    arsp.b_valid = 1'b1; arsp.b.resp = b_resp_cfg; arsp.b.id = TB_ID; b_pend = 0;
                end
                if (r_pend) begin
                    if (r_wait >= r_lat) begin
                        arsp.r_valid = 1'b1; arsp.r.resp = r_resp_cfg; arsp.r.id = TB_ID; arsp.r.last = 1'b1;
                        arsp.r.data = sub_mem.exists(ar_addr_s) ? sub_mem[ar_addr_s] : 32'd0;
                        r_pend = 0;
                    end else r_wait++;
                end
                b_fp = arsp.b_valid && areq.b_ready;
                if (b_fp) n_b++;
                r_fp = arsp.r_valid && areq.r_ready;
                if (r_fp) n_r++;
                arsp.aw_ready = areq.aw_valid && (aw_wait >= aw_lat);
                if (areq.aw_valid && !arsp.aw_ready) aw_wait++;
                if (areq.aw_valid && arsp.aw_ready) begin
                    aw_fp = 1; aw_got = 1; aw_wait = 0; n_aw++; aw_addr_s = areq.aw.addr;
                    check_val("aw_addr", 64'(areq.aw.addr), 64'(cur_addr));
                    check_val("aw_fixed", 64'({areq.aw.len, areq.aw.size, areq.aw.burst, areq.aw.id,
                        areq.aw.lock, areq.aw.cache, areq.aw.prot, areq.aw.qos, areq.aw.region,
                        areq.aw.atop, areq.aw.user}), 64'(exp_aw_fix));
                end
                arsp.w_ready = areq.w_valid && (w_wait >= w_lat);
                if (areq.w_valid && !arsp.w_ready) w_wait++;
                if (areq.w_valid && arsp.w_ready) begin
                    w_fp = 1; w_got = 1; w_wait = 0; n_w++; w_data_s = areq.w.data; w_strb_s = areq.w.strb;
                    check_val("w_data", 64'(areq.w.data), 64'(cur_wdata));
                    check_val("w_strb_last", 64'({areq.w.strb, areq.w.last}), 64'({cur_wstrb, 1'b1}));
                end
                arsp.ar_ready = areq.ar_valid && (ar_wait >= ar_lat);
                if (areq.ar_valid && !arsp.ar_ready) ar_wait++;
                if (areq.ar_valid && arsp.ar_ready) begin
                    ar_fp = 1; r_pend = 1; r_wait = 0; ar_wait = 0; n_ar++; ar_addr_s = areq.ar.addr;
                    check_val("ar_addr", 64'(areq.ar.addr), 64'(cur_addr));
                    check_val("ar_fixed", 64'({areq.ar.len, areq.ar.size, areq.ar.burst, areq.ar.id,
                        areq.ar.lock, areq.ar.cache, areq.ar.prot, areq.ar.qos, areq.ar.region,
                        areq.ar.user}), 64'(exp_ar_fix));
                end
                if (aw_got && w_got) begin
                    if (b_resp_cfg < 2'd2)
                        sub_mem[aw_addr_s] = merge(sub_mem.exists(aw_addr_s) ? sub_mem[aw_addr_s] : 32'd0,
                                                   w_data_s, w_strb_s);
                    b_pend = 1; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    // count regbus ready pulses and flag back-to-back pulses
    initial begin
        forever begin
            @(negedge clk);
            if (rsp.ready) begin
                n_rdy++;
                if (rdy_prev) n_consec++;
            end
            rdy_prev = rsp.ready;
        end
    end

    // One regbus access; starts at a falling edge and returns at the one where ready is seen
    task automatic reg_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input bit drop, input int lat_extra);
        logic [31:0] old_v, exp_rdata;
        bit exp_err;
        int lat, exp_lat;
        old_v = ref_mem.exists(addr) ? ref_mem[addr] : 32'd0;
        exp_err = wr ? (b_resp_cfg >= 2'd2) : (r_resp_cfg >= 2'd2);
        exp_rdata = wr ? 32'd0 : old_v;
        if (wr && !exp_err) ref_mem[addr] = merge(old_v, data, strb);
        exp_lat = lat_extra + (wr ? 4 + ((aw_lat > w_lat) ? aw_lat : w_lat) : 4 + ar_lat + r_lat);
        if (wr) begin exp_aw++; exp_w++; exp_b++; end
        else begin exp_ar++; exp_r++; end
        exp_rdy++;
        cur_addr = addr; cur_wdata = data; cur_wstrb = strb;
        req.valid = 1'b1; req.write = wr; req.addr = addr; req.wdata = data; req.wstrb = strb;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
            if (drop && lat == 2) req.valid = 1'b0;
        end while (!rsp.ready && lat < 200);
        check_val(wr ? "wr_latency" : "rd_latency", 64'(lat), 64'(exp_lat));
        check_val(wr ? "wr_error" : "rd_error", 64'(rsp.error), 64'(exp_err));
        check_val(wr ? "wr_rdata" : "rd_rdata", 64'(rsp.rdata), 64'(exp_rdata));
    endtask

    task automatic idle_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit drop);
        reg_access(wr, addr, data, strb, drop, 0);
        req.valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t;
        exp_aw_fix = {8'd0, 3'd2, 2'b01, TB_ID, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0};
        exp_ar_fix = {8'd0, 3'd2, 2'b01, TB_ID, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
        rst_n = 1'b0;
        req = '0;
        #1;
        check_val("rst_axi_valids", 64'({areq.aw_valid, areq.w_valid, areq.ar_valid, areq.b_ready, areq.r_ready}), 64'd0);
        check_val("rst_reg_rsp", 64'(rsp), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // write with AW accepted 3 cycles late
        aw_lat = 3; w_lat = 0;
        idle_access(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
        // read of preloaded subordinate contents
        aw_lat = 0; sub_mem[32'h80] = 32'hDEADBEEF; ref_mem[32'h80] = 32'hDEADBEEF;
        idle_access(1'b0, 32'h80, 32'd0, 4'h0, 1'b0);
        // error responses; the failed write leaves memory alone, the failed read keeps its data
        idle_access(1'b1, 32'h100, 32'h1234, 4'hF, 1'b0);
        b_resp_cfg = 2'b10;
        idle_access(1'b1, 32'h100, 32'hFFFF0000, 4'hF, 1'b0);
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
        idle_access(1'b0, 32'h100, 32'd0, 4'h0, 1'b0);
        r_resp_cfg = 2'b00;
        // back-to-back write then read with valid held
        reg_access(1'b1, 32'h44, 32'hA5A5_5A5A, 4'h5, 1'b0, 0);
        reg_access(1'b0, 32'h44, 32'd0, 4'h0, 1'b0, 1);
        req.valid = 1'b0;
        @(negedge clk);
        // W five cycles ahead of AW, then both in the same cycle
        aw_lat = 5; w_lat = 0;
        idle_access(1'b1, 32'h48, 32'h0BAD_F00D, 4'hC, 1'b0);
        aw_lat = 0;
        idle_access(1'b1, 32'h4C, 32'h1357_9BDF, 4'h3, 1'b0);

        // reset while waiting for R
        r_lat = 50; cur_addr = 32'h80;
        req.valid = 1'b1; req.write = 1'b0; req.addr = 32'h80;
        exp_ar++;
        t = 0;
        while (!areq.r_ready && t < 20) begin @(negedge clk); t++; end
        check_val("reach_wait_r", 64'(t < 20), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_axi_valids", 64'({areq.aw_valid, areq.w_valid, areq.ar_valid, areq.b_ready, areq.r_ready}), 64'd0);
        check_val("midrst_reg_rsp", 64'(rsp), 64'd0);
        @(negedge clk);
        req.valid = 1'b0; r_lat = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_access(1'b0, 32'h80, 32'd0, 4'h0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            b_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            idle_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                        4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
        end
        repeat (3) @(negedge clk);

        check_val("aw_count", 64'(n_aw), 64'(exp_aw));
        check_val("w_count", 64'(n_w), 64'(exp_w));
        check_val("ar_count", 64'(n_ar), 64'(exp_ar));
        check_val("b_count", 64'(n_b), 64'(exp_b));
        check_val("r_count", 64'(n_r), 64'(exp_r));
        check_val("ready_pulses", 64'(n_rdy), 64'(exp_rdy));
        check_val("ready_consecutive", 64'(n_consec), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
